queue_block_ctrl: RTL and testbench
===================================

# queue_block_ctrl

Animation and bump sequencer for the question ("queue") block sprites drawn by the queue sprite color units.
- Drives each block's one-bit `animate_state`: 0 = QUEUE_LEFT frame, 1 = QUEUE_RIGHT frame.
- Runs one shared bump engine. When Mario hits a block from below, the engine lifts that block and drops it back, then marks it used.
- Sits between the game-logic collision unit, which issues hits, and the sprite renderers, which consume frame selects and the row offset.

## Interface
Parameters:
- `NUM_BLOCKS`, 4: number of queue blocks managed.
- `IDX_W`, 2: width of block index. Must satisfy 2^IDX_W >= NUM_BLOCKS.
- `TOGGLE_FRAMES`, 16: frame ticks per animation phase.
- `BUMP_HEIGHT`, 8: peak bump displacement in pixels, range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame, at vblank start.
- `hit_valid`, in, 1: hit request.
- `hit_idx`, in, IDX_W: block index of the hit.
- `hit_ready`, out, 1: engine can accept a hit.
- `clear_used`, in, 1: one-cycle pulse that clears all used flags (level restart).
- `animate_state`, out, NUM_BLOCKS: per-block frame select.
- `used`, out, NUM_BLOCKS: per-block used flag.
- `bump_active`, out, 1: bump engine busy.
- `bump_idx`, out, IDX_W: block currently bumping.
- `bump_offset`, out, 4: upward pixel offset for `bump_idx`. The renderer subtracts it from posy.
- `coin_pulse`, out, 1: one-cycle reward strobe.

## Operation
- **Phase counter**
  - `frame_cnt` counts `frame_tick` pulses over 0..TOGGLE_FRAMES-1.
  - At the wrap tick (cnt == TOGGLE_FRAMES-1), `frame_cnt` returns to 0 and `phase` toggles.
  - It runs regardless of engine state.
- **animate_state[i]**
  - `phase` when block i is neither used nor bumping.
  - 0 when block i is used, or when block i is bumping (bump_active && bump_idx == i).
- **Bump engine FSM** (states IDLE, UP, DOWN):
  - **IDLE**:
    - `hit_ready` = 1, from combinational state decode.
    - On `hit_valid` with `hit_idx` < NUM_BLOCKS and `used[hit_idx]` == 0: latch `bump_idx`, set `bump_offset` = 0, pulse `coin_pulse`, go to UP.
    - On a hit to a used block or an out-of-range index: the handshake completes and the hit is dropped. No pulse, no state change.
  - **UP**:
    - On each `frame_tick`, `bump_offset` += 1.
    - The tick that sets the offset to BUMP_HEIGHT also moves the FSM to DOWN.
  - **DOWN**:
    - On each `frame_tick`, `bump_offset` -= 1.
    - The tick that sets the offset to 0 also sets `used[bump_idx]` and returns to IDLE.
  - `bump_active` = (state != IDLE). `hit_ready` = 0 in UP and DOWN. Hits presented then are held off by the requester, not queued.
- **clear_used**
  - Zeroes all `used` bits in the next cycle.
  - It does not disturb an in-flight bump; that bump still sets its used bit on completion.
  - If `clear_used` and bump completion coincide, the completing block's used bit ends at 1 and all others end at 0.
- **Arithmetic**: `bump_offset` is 4-bit unsigned and never wraps. The range is 0..BUMP_HEIGHT.

## Timing
- **Reset values**: state IDLE, `frame_cnt` = 0, `phase` = 0, `used` = 0, `animate_state` = 0, `bump_active` = 0, `bump_idx` = 0, `bump_offset` = 0, `coin_pulse` = 0, `hit_ready` = 1.
- **Reset mid-bump**: aborts the bump immediately. Everything returns to reset values and the interrupted block is not marked used.
- **Hit latency**:
  - Hit accepted at edge t.
  - `coin_pulse` = 1 and `bump_active` = 1 during cycle t+1 only; `coin_pulse` returns to 0 at t+2.
  - A `frame_tick` coincident with acceptance does not advance the offset.
  - It still advances `frame_cnt`.
- **Bump duration**: exactly 2 × BUMP_HEIGHT frame ticks after acceptance. `used` rises on the same edge that `bump_active` falls.
- **Next hit**: accepted no earlier than the cycle after `bump_active` falls.
- All outputs are registered except `hit_ready`.

## Test plan
- Reset, then 16 frame ticks: all `animate_state` bits go 0 → 1 exactly at the 16th tick; after 32 ticks they are back to 0.
- `hit_idx` = 2 accepted: `coin_pulse` is high for one cycle; `bump_offset` steps 1..8 then 7..0 over 16 ticks; `used` = 4'b0100 afterward; `animate_state[2]` is held 0 while the other bits keep toggling.
- Second hit to block 2 after it is used: `hit_ready` = 1, no `coin_pulse`, `bump_active` stays 0. A hit with `hit_idx` = 3 and NUM_BLOCKS = 3 is likewise dropped.
- `hit_valid` during a bump on block 1: `hit_ready` = 0 throughout; the request is accepted the cycle after `bump_active` = 0.
- `rst_n` asserted at `bump_offset` = 5: all outputs are zero immediately and `used[idx]` stays 0. `clear_used` coincident with bump completion on block 0, with `used` = 4'b1010 beforehand: `used` = 4'b0001.

Source files
------------

// File: rtl/queue_block_ctrl.sv
// Question-block animation phase and shared bump engine: drives per-block frame
// selects, lifts and drops a hit block over frame ticks, then marks it used.
module queue_block_ctrl #(
    parameter int NUM_BLOCKS    = 4,
    parameter int IDX_W         = 2,
    parameter int TOGGLE_FRAMES = 16,
    parameter int BUMP_HEIGHT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  hit_valid,
    input  logic [IDX_W-1:0]      hit_idx,
    output logic                  hit_ready,
    input  logic                  clear_used,
    output logic [NUM_BLOCKS-1:0] animate_state,
    output logic [NUM_BLOCKS-1:0] used,
    output logic                  bump_active,
    output logic [IDX_W-1:0]      bump_idx,
    output logic [3:0]            bump_offset,
    output logic                  coin_pulse
);
    localparam int CNT_W = (TOGGLE_FRAMES > 1) ? $clog2(TOGGLE_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_BLOCKS-1:0] used_q, used_d;
    logic [NUM_BLOCKS-1:0] anim_q, anim_d;
    logic                  active_q, active_d;
    logic [IDX_W-1:0]      bump_idx_q, bump_idx_d;
    logic [3:0]            offset_q, offset_d;
    logic                  coin_q, coin_d;
    logic                  hit_ok;
    logic                  bump_done;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        bump_idx_d  = bump_idx_q;
        offset_d    = offset_q;
        coin_d      = 1'b0;
        hit_ok      = 1'b0;
        bump_done   = 1'b0;

        if (frame_tick) begin
            if (frame_cnt_q == CNT_W'(TOGGLE_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Index loop doubles as the range check, so out-of-range hits never match.
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (hit_idx == IDX_W'(i) && !used_q[i]) hit_ok = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hit_valid && hit_ok) begin
                    state_d    = UP;
                    bump_idx_d = hit_idx;
                    offset_d   = '0;
                    coin_d     = 1'b1;
                end
            end
            UP: begin
                if (frame_tick) begin
                    offset_d = offset_q + 4'd1;
                    if (offset_q + 4'd1 == 4'(BUMP_HEIGHT)) state_d = DOWN;
                end
            end
            DOWN: begin
                if (frame_tick) begin
                    offset_d = offset_q - 4'd1;
                    if (offset_q == 4'd1) begin
                        state_d   = IDLE;
                        bump_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion wins over a coincident clear for the bumped block only.
        used_d = clear_used ? '0 : used_q;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (bump_done && bump_idx_q == IDX_W'(i)) used_d[i] = 1'b1;
        end

        active_d = (state_d != IDLE);
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            anim_d[i] = (used_d[i] || (active_d && bump_idx_d == IDX_W'(i))) ? 1'b0 : phase_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            used_q      <= '0;
            anim_q      <= '0;
            active_q    <= 1'b0;
            bump_idx_q  <= '0;
            offset_q    <= '0;
            coin_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            used_q      <= used_d;
            anim_q      <= anim_d;
            active_q    <= active_d;
            bump_idx_q  <= bump_idx_d;
            offset_q    <= offset_d;
            coin_q      <= coin_d;
        end
    end

    assign hit_ready     = (state_q == IDLE);
    assign animate_state = anim_q;
    assign used          = used_q;
    assign bump_active   = active_q;
    assign bump_idx      = bump_idx_q;
    assign bump_offset   = offset_q;
    assign coin_pulse    = coin_q;
endmodule

// File: tb/tb_queue_block_ctrl.sv
// Directed bench for queue_block_ctrl: table of per-cycle vectors for a full bump,
// plus hand sequences for drops, held requests, reset mid-bump and clear races.
module tb_queue_block_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, hit_valid, clear_used;
    logic [1:0] hit_idx;
    logic       hit_ready, bump_active, coin_pulse;
    logic [3:0] animate_state, used, bump_offset;
    logic [1:0] bump_idx;

    logic       hv3;
    logic [1:0] idx3;
    logic       r3, act3, coin3;
    logic [2:0] anim3, used3;
    logic [1:0] bidx3;
    logic [3:0] off3;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    queue_block_ctrl #(.NUM_BLOCKS(4), .IDX_W(2), .TOGGLE_FRAMES(16), .BUMP_HEIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit_valid(hit_valid),
        .hit_idx(hit_idx), .hit_ready(hit_ready), .clear_used(clear_used),
        .animate_state(animate_state), .used(used), .bump_active(bump_active),
        .bump_idx(bump_idx), .bump_offset(bump_offset), .coin_pulse(coin_pulse)
    );

    queue_block_ctrl #(.NUM_BLOCKS(3), .IDX_W(2), .TOGGLE_FRAMES(16), .BUMP_HEIGHT(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit_valid(hv3),
        .hit_idx(idx3), .hit_ready(r3), .clear_used(clear_used),
        .animate_state(anim3), .used(used3), .bump_active(act3),
        .bump_idx(bidx3), .bump_offset(off3), .coin_pulse(coin3)
    );

    typedef struct {
        logic       tick;
        logic       hv;
        logic [1:0] idx;
        logic       clr;
        logic       e_ready;
        logic       e_active;
        logic [1:0] e_idx;
        logic [3:0] e_off;
        logic       e_coin;
        logic [3:0] e_used;
        logic [3:0] e_anim;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input logic t, input logic v, input logic [1:0] i, input logic c);
        frame_tick = t; hit_valid = v; hit_idx = i; clear_used = c;
        @(posedge clk); #1;
        frame_tick = 1'b0; hit_valid = 1'b0; clear_used = 1'b0;
    endtask

    task automatic do_bump(input logic [1:0] i);
        cyc(1'b0, 1'b1, i, 1'b0);
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int fall_n, acc_n;
        logic held_ok;

        // tick hv idx clr | ready active idx off coin used anim
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b1, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd1, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd4, 1'b0, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd6, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd7, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd8, 1'b0, 4'b0000, 4'b1011};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd7, 1'b0, 4'b0000, 4'b1011};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd6, 1'b0, 4'b0000, 4'b1011};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 4'b0000, 4'b1011};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd4, 1'b0, 4'b0000, 4'b1011};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 4'b0000, 4'b1011};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0, 4'b0000, 4'b1011};
        vecs[16] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd1, 1'b0, 4'b0000, 4'b1011};
        vecs[17] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 4'b0100, 4'b1011};

        rst_n = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0; hit_idx = 2'd0; clear_used = 1'b0;
        hv3 = 1'b0; idx3 = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", hit_ready, 1);
        chk("rst_active", bump_active, 0);
        chk("rst_offset", bump_offset, 0);
        chk("rst_idx", bump_idx, 0);
        chk("rst_coin", coin_pulse, 0);
        chk("rst_used", used, 0);
        chk("rst_anim", animate_state, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Phase toggles on the 16th tick and returns on the 32nd.
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b0);
            if (k == 15) chk("anim_t15", animate_state, 4'b0000);
            if (k == 16) chk("anim_t16", animate_state, 4'b1111);
            if (k == 31) chk("anim_t31", animate_state, 4'b1111);
            if (k == 32) chk("anim_t32", animate_state, 4'b0000);
            cyc(1'b0, 1'b0, 2'd0, 1'b0);
        end
        // Park the frame counter at 8 so the phase flips mid-bump.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("anim_pre_bump", animate_state, 4'b0000);

        foreach (vecs[r]) begin
            cyc(vecs[r].tick, vecs[r].hv, vecs[r].idx, vecs[r].clr);
            chk($sformatf("v%0d_ready", r), hit_ready, vecs[r].e_ready);
            chk($sformatf("v%0d_active", r), bump_active, vecs[r].e_active);
            if (vecs[r].e_active) chk($sformatf("v%0d_idx", r), bump_idx, vecs[r].e_idx);
            chk($sformatf("v%0d_offset", r), bump_offset, vecs[r].e_off);
            chk($sformatf("v%0d_coin", r), coin_pulse, vecs[r].e_coin);
            chk($sformatf("v%0d_used", r), used, vecs[r].e_used);
            chk($sformatf("v%0d_anim", r), animate_state, vecs[r].e_anim);
        end

        // Hits to a used block, and to an out-of-range index, are dropped.
        hit_valid = 1'b1; hit_idx = 2'd2; hv3 = 1'b1; idx3 = 2'd3;
        #1;
        chk("drop_ready", hit_ready, 1);
        chk("drop3_ready", r3, 1);
        @(posedge clk); #1;
        hit_valid = 1'b0; hv3 = 1'b0;
        chk("drop_coin", coin_pulse, 0);
        chk("drop_active", bump_active, 0);
        chk("drop_ready_after", hit_ready, 1);
        chk("drop3_coin", coin3, 0);
        chk("drop3_active", act3, 0);
        chk("drop3_used", used3, 0);

        // Request held during a bump on block 1 is taken the cycle after it ends.
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        chk("b1_coin", coin_pulse, 1);
        chk("b1_idx", bump_idx, 1);
        fall_n = 0; acc_n = 0; held_ok = 1'b1;
        for (int n = 1; n <= 40 && acc_n == 0; n++) begin
            frame_tick = 1'b1; hit_valid = 1'b1; hit_idx = 2'd0;
            if (bump_active && hit_ready) held_ok = 1'b0;
            @(posedge clk); #1;
            if (!bump_active && fall_n == 0) fall_n = n;
            if (coin_pulse) acc_n = n;
        end
        frame_tick = 1'b0; hit_valid = 1'b0;
        chk("held_ready_low", held_ok, 1);
        chk("held_fall_tick", fall_n, 16);
        chk("held_accept", acc_n, 17);
        chk("held_idx", bump_idx, 0);
        chk("held_offset_coincident_tick", bump_offset, 0);
        chk("held_used", used, 4'b0110);

        // Reset mid-bump on block 0.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("mid_offset", bump_offset, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_active", bump_active, 0);
        chk("mid_rst_offset", bump_offset, 0);
        chk("mid_rst_used", used, 0);
        chk("mid_rst_anim", animate_state, 0);
        chk("mid_rst_idx", bump_idx, 0);
        chk("mid_rst_ready", hit_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("post_rst_used", used, 0);
        chk("post_rst_active", bump_active, 0);

        // Clear coincident with completion of block 0.
        do_bump(2'd1);
        do_bump(2'd3);
        chk("pre_clear_used", used, 4'b1010);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("pre_clear_offset", bump_offset, 1);
        cyc(1'b1, 1'b0, 2'd0, 1'b1);
        chk("clear_race_used", used, 4'b0001);
        chk("clear_race_active", bump_active, 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        chk("clear_alone_used", used, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
